// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Micro-op encoding, ISA-wide constants and trace formatting for the ALU
package alu_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_BITS = 5;
  localparam int SHAMT_BITS    = 5;
  localparam int TRACE_CHARS   = 17;

  // Encodings 11..15 are left unassigned; the ALU completes them with wen=0.
  typedef enum logic [3:0] {
    UOP_ADD  = 4'd0,
    UOP_SUB  = 4'd1,
    UOP_AND  = 4'd2,
    UOP_OR   = 4'd3,
    UOP_XOR  = 4'd4,
    UOP_SLL  = 4'd5,
    UOP_SRL  = 4'd6,
    UOP_SRA  = 4'd7,
    UOP_SLT  = 4'd8,
    UOP_SLTU = 4'd9,
    UOP_LUI  = 4'd10
  } rv_uop;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // "pppppppp:dddddddd" while a result is valid, all blanks otherwise.
  function automatic logic [8*TRACE_CHARS-1:0] alu_trace(
    input logic            val,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] wdata
  );
    logic [8*TRACE_CHARS-1:0] s;
    s = {TRACE_CHARS{8'h20}};
    if (val) begin
      for (int i = 0; i < 8; i++) begin
        s[8*(TRACE_CHARS-1-i) +: 8] = hex_char(pc[4*(7-i) +: 4]);
        s[8*(7-i) +: 8]             = hex_char(wdata[4*(7-i) +: 4]);
      end
      s[8*8 +: 8] = 8'h3a;
    end
    return s;
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - Combinational integer datapath: (uop, op1, op2) -> (wdata, wen)
module alu_datapath
  import alu_pkg::*;
(
  input  rv_uop           i_uop,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_wen
);

  logic [SHAMT_BITS-1:0] w_shamt;
  logic                  w_lt_signed;
  logic                  w_lt_unsigned;

  assign w_shamt       = i_op2[SHAMT_BITS-1:0];
  assign w_lt_signed   = $signed(i_op1) < $signed(i_op2);
  assign w_lt_unsigned = i_op1 < i_op2;

  always_comb begin
    o_wdata = '0;
    o_wen   = 1'b1;
    case (i_uop)
      UOP_ADD:  o_wdata = i_op1 + i_op2;
      UOP_SUB:  o_wdata = i_op1 - i_op2;
      UOP_AND:  o_wdata = i_op1 & i_op2;
      UOP_OR:   o_wdata = i_op1 | i_op2;
      UOP_XOR:  o_wdata = i_op1 ^ i_op2;
      UOP_SLL:  o_wdata = i_op1 << w_shamt;
      UOP_SRL:  o_wdata = i_op1 >> w_shamt;
      UOP_SRA:  o_wdata = $unsigned($signed(i_op1) >>> w_shamt);
      UOP_SLT:  o_wdata = {{(XLEN-1){1'b0}}, w_lt_signed};
      UOP_SLTU: o_wdata = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      UOP_LUI:  o_wdata = i_op2;
      default: begin
        o_wdata = '0;
        o_wen   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - Single-cycle ALU execute unit with a one-entry val/rdy output register
module alu
  import alu_pkg::*;
#(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      D_val,
  output logic                      D_rdy,
  input  logic [XLEN-1:0]           D_pc,
  input  logic [p_seq_num_bits-1:0] D_seq_num,
  input  logic [XLEN-1:0]           D_op1,
  input  logic [XLEN-1:0]           D_op2,
  input  logic [REG_ADDR_BITS-1:0]  D_waddr,
  input  rv_uop                     D_uop,

  output logic                      W_val,
  input  logic                      W_rdy,
  output logic [XLEN-1:0]           W_pc,
  output logic [p_seq_num_bits-1:0] W_seq_num,
  output logic [REG_ADDR_BITS-1:0]  W_waddr,
  output logic [XLEN-1:0]           W_wdata,
  output logic                      W_wen
);

  logic                      r_val;
  logic [XLEN-1:0]           r_pc;
  logic [p_seq_num_bits-1:0] r_seq_num;
  logic [REG_ADDR_BITS-1:0]  r_waddr;
  logic [XLEN-1:0]           r_wdata;
  logic                      r_wen;

  logic [XLEN-1:0]           w_wdata;
  logic                      w_wen;
  logic                      w_accept;

  // Accept when the slot is empty or is being drained this same cycle.
  assign D_rdy    = !r_val || W_rdy;
  assign w_accept = D_val && D_rdy;

  alu_datapath u_datapath (
    .i_uop   (D_uop),
    .i_op1   (D_op1),
    .i_op2   (D_op2),
    .o_wdata (w_wdata),
    .o_wen   (w_wen)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val     <= 1'b0;
      r_pc      <= '0;
      r_seq_num <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wen     <= 1'b0;
    end else if (w_accept) begin
      r_val     <= 1'b1;
      r_pc      <= D_pc;
      r_seq_num <= D_seq_num;
      r_waddr   <= D_waddr;
      r_wdata   <= w_wdata;
      r_wen     <= w_wen;
    end else if (W_rdy) begin
      r_val     <= 1'b0;
    end
  end

  assign W_val     = r_val;
  assign W_pc      = r_pc;
  assign W_seq_num = r_seq_num;
  assign W_waddr   = r_waddr;
  assign W_wdata   = r_wdata;
  assign W_wen     = r_wen;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - Scoreboard-driven self-checking bench for the ALU execute unit
module tb_alu
  import alu_pkg::*;
;

  localparam int SEQ_BITS = 3;

  typedef struct {
    logic [31:0]         pc;
    logic [SEQ_BITS-1:0] seq;
    logic [4:0]          waddr;
    rv_uop               uop;
    logic [31:0]         op1;
    logic [31:0]         op2;
    logic [31:0]         wdata;
    logic                wen;
  } op_t;

  logic                clk;
  logic                rst;
  logic                D_val;
  logic                D_rdy;
  logic [31:0]         D_pc;
  logic [SEQ_BITS-1:0] D_seq_num;
  logic [31:0]         D_op1;
  logic [31:0]         D_op2;
  logic [4:0]          D_waddr;
  rv_uop               D_uop;
  logic                W_val;
  logic                W_rdy;
  logic [31:0]         W_pc;
  logic [SEQ_BITS-1:0] W_seq_num;
  logic [4:0]          W_waddr;
  logic [31:0]         W_wdata;
  logic                W_wen;

  op_t stim_q[$];
  op_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  first_cyc;
  int  last_cyc;

  alu #(.p_seq_num_bits(SEQ_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .D_val     (D_val),
    .D_rdy     (D_rdy),
    .D_pc      (D_pc),
    .D_seq_num (D_seq_num),
    .D_op1     (D_op1),
    .D_op2     (D_op2),
    .D_waddr   (D_waddr),
    .D_uop     (D_uop),
    .W_val     (W_val),
    .W_rdy     (W_rdy),
    .W_pc      (W_pc),
    .W_seq_num (W_seq_num),
    .W_waddr   (W_waddr),
    .W_wdata   (W_wdata),
    .W_wen     (W_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic op_t mk(input logic [31:0] pc, input int seq, input logic [4:0] waddr,
                             input rv_uop uop, input logic [31:0] op1, input logic [31:0] op2,
                             input logic [31:0] wdata, input logic wen);
    op_t o;
    o.pc = pc; o.seq = SEQ_BITS'(seq); o.waddr = waddr; o.uop = uop;
    o.op1 = op1; o.op2 = op2; o.wdata = wdata; o.wen = wen;
    return o;
  endfunction

  function automatic op_t with_model(input op_t o);
    logic signed [31:0] s;
    s     = o.op1;
    o.wen = 1'b1;
    case (o.uop)
      UOP_ADD:  o.wdata = o.op1 + o.op2;
      UOP_SUB:  o.wdata = o.op1 - o.op2;
      UOP_AND:  o.wdata = o.op1 & o.op2;
      UOP_OR:   o.wdata = o.op1 | o.op2;
      UOP_XOR:  o.wdata = o.op1 ^ o.op2;
      UOP_SLL:  o.wdata = o.op1 << o.op2[4:0];
      UOP_SRL:  o.wdata = o.op1 >> o.op2[4:0];
      UOP_SRA:  o.wdata = s >>> o.op2[4:0];
      UOP_SLT:  o.wdata = (s < $signed(o.op2)) ? 32'd1 : 32'd0;
      UOP_SLTU: o.wdata = (o.op1 < o.op2) ? 32'd1 : 32'd0;
      UOP_LUI:  o.wdata = o.op2;
      default: begin o.wdata = 32'd0; o.wen = 1'b0; end
    endcase
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    D_val = 1'b1; D_pc = o.pc; D_seq_num = o.seq; D_waddr = o.waddr;
    D_uop = o.uop; D_op1 = o.op1; D_op2 = o.op2;
  endtask

  // Streams stim_q through the DUT with random D send and W receive delays.
  task automatic run_stream(input int dmax, input int wmax, input string tag);
    int n;
    int got;
    n = stim_q.size();
    got = 0;
    first_cyc = -1;
    last_cyc = -1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int  dly;
          int  guard;
          bit  acc;
          dly = $urandom_range(0, dmax);
          D_val = 1'b0;
          repeat (dly) begin @(posedge clk); #1; end
          drive_op(stim_q[i]);
          exp_q.push_back(stim_q[i]);
          guard = 0;
          do begin
            @(negedge clk); acc = D_rdy;
            @(posedge clk); #1; guard++;
          end while (!acc && guard < 100);
          if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL %s send_timeout op=%0d D_rdy stuck at %0b, required 1", tag, i, D_rdy);
          end
        end
        D_val = 1'b0;
      end
      begin
        int wait_cnt;
        int cycles;
        wait_cnt = $urandom_range(0, wmax);
        cycles = 0;
        while (got < n && cycles < 2000) begin
          W_rdy = (wait_cnt == 0);
          @(negedge clk);
          if (W_val && W_rdy) begin
            op_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL %s spurious result pc=%h wdata=%h, required none", tag, W_pc, W_wdata);
            end else begin
              e = exp_q.pop_front();
              if (W_pc !== e.pc || W_seq_num !== e.seq || W_waddr !== e.waddr ||
                  W_wdata !== e.wdata || W_wen !== e.wen) begin
                n_fail++;
                $display("FAIL %s result#%0d got pc=%h seq=%0d waddr=%0d wdata=%h wen=%0b required pc=%h seq=%0d waddr=%0d wdata=%h wen=%0b",
                         tag, got, W_pc, W_seq_num, W_waddr, W_wdata, W_wen,
                         e.pc, e.seq, e.waddr, e.wdata, e.wen);
              end
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
            wait_cnt = $urandom_range(0, wmax);
          end else if (wait_cnt > 0) begin
            wait_cnt--;
          end
          @(posedge clk); #1; cycles++;
        end
        W_rdy = 1'b1;
      end
    join
    n_checks++;
    if (got != n || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s count received=%0d leftover=%0d, required received=%0d leftover=0",
               tag, got, exp_q.size(), n);
    end
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; D_val = 1'b0; W_rdy = 1'b1; D_pc = '0; D_seq_num = '0;
    D_op1 = '0; D_op2 = '0; D_waddr = '0; D_uop = UOP_ADD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (W_val !== 1'b0 || W_pc !== 32'd0 || W_seq_num !== '0 || W_waddr !== 5'd0 ||
        W_wdata !== 32'd0 || W_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got val=%0b pc=%h seq=%0d waddr=%0d wdata=%h wen=%0b required all 0",
               W_val, W_pc, W_seq_num, W_waddr, W_wdata, W_wen);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (D_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_d_rdy got %0b required 1", D_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    op_t e;
    W_rdy = 1'b1;
    e = mk(32'h200, 1, 5'd5, UOP_ADD, 32'd1, 32'd2, 32'd3, 1'b1);
    drive_op(e);
    exp_q.push_back(e);
    @(negedge clk);
    n_checks++;
    if (W_val !== 1'b0 || D_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_pre got W_val=%0b D_rdy=%0b required W_val=0 D_rdy=1", W_val, D_rdy);
    end
    @(posedge clk); #1; D_val = 1'b0;
    @(negedge clk);
    n_checks++;
    e = exp_q.pop_front();
    if (W_val !== 1'b1 || W_pc !== e.pc || W_seq_num !== e.seq || W_waddr !== e.waddr ||
        W_wdata !== e.wdata || W_wen !== e.wen) begin
      n_fail++;
      $display("FAIL add_latency got val=%0b pc=%h seq=%0d waddr=%0d wdata=%h wen=%0b required val=1 pc=%h seq=%0d waddr=%0d wdata=%h wen=1",
               W_val, W_pc, W_seq_num, W_waddr, W_wdata, W_wen, e.pc, e.seq, e.waddr, e.wdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (W_val !== 1'b0) begin
      n_fail++;
      $display("FAIL add_drain got W_val=%0b required 0", W_val);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    stim_q.push_back(mk(32'h1000, 0, 5'd1, UOP_ADD,  32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b1));
    stim_q.push_back(mk(32'h1004, 1, 5'd2, UOP_SUB,  32'd0,         32'd1,        32'hFFFF_FFFF, 1'b1));
    stim_q.push_back(mk(32'h1008, 2, 5'd3, UOP_SLT,  32'hFFFF_FFFF, 32'd1,        32'd1,         1'b1));
    stim_q.push_back(mk(32'h100c, 3, 5'd4, UOP_SLTU, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1));
    stim_q.push_back(mk(32'h1010, 4, 5'd5, UOP_SRA,  32'h8000_0000, 32'd4,        32'hF800_0000, 1'b1));
    stim_q.push_back(mk(32'h1014, 5, 5'd6, UOP_SRL,  32'h8000_0000, 32'd4,        32'h0800_0000, 1'b1));
    stim_q.push_back(mk(32'h1018, 6, 5'd7, UOP_SLL,  32'd3,         32'h0000_0021, 32'd6,        1'b1));
    stim_q.push_back(mk(32'h101c, 7, 5'd8, UOP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b1));
    stim_q.push_back(mk(32'h1020, 0, 5'd9, UOP_OR,   32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b1));
    stim_q.push_back(mk(32'h1024, 1, 5'd10, UOP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b1));
    stim_q.push_back(mk(32'h1028, 2, 5'd11, UOP_LUI, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b1));
    stim_q.push_back(mk(32'h102c, 3, 5'd12, rv_uop'(4'd13), 32'd9,  32'd9,        32'd0,         1'b0));
    stim_q.push_back(mk(32'h1030, 4, 5'd0, UOP_ADD,  32'd40,        32'd2,        32'd42,        1'b1));
    run_stream(0, 0, "ops");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      stim_q.push_back(mk(32'h2000 + 32'(4*i), i, 5'(i + 1), UOP_ADD, 32'(100*i), 32'd7, 32'(100*i + 7), 1'b1));
    run_stream(0, 0, "b2b");
    n_checks++;
    if (last_cyc - first_cyc != 7) begin
      n_fail++;
      $display("FAIL b2b_throughput got span=%0d cycles required 7", last_cyc - first_cyc);
    end
  endtask

  task automatic test_backpressure();
    op_t a;
    op_t b;
    logic [8*TRACE_CHARS-1:0] exp_trace;
    logic [8*TRACE_CHARS-1:0] blank_trace;
    exp_trace   = "00000300:0000000c";
    blank_trace = "                 ";
    W_rdy = 1'b1;
    a = mk(32'h300, 2, 5'd3, UOP_ADD, 32'd5, 32'd7, 32'd12, 1'b1);
    b = mk(32'h304, 3, 5'd4, UOP_SUB, 32'd10, 32'd3, 32'd7, 1'b1);
    drive_op(a); exp_q.push_back(a);
    @(posedge clk); #1;
    W_rdy = 1'b0;
    drive_op(b); exp_q.push_back(b);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (W_val !== 1'b1 || W_pc !== exp_q[0].pc || W_seq_num !== exp_q[0].seq ||
          W_waddr !== exp_q[0].waddr || W_wdata !== exp_q[0].wdata || W_wen !== 1'b1 || D_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d got val=%0b pc=%h wdata=%h D_rdy=%0b required val=1 pc=%h wdata=%h D_rdy=0",
                 k, W_val, W_pc, W_wdata, D_rdy, exp_q[0].pc, exp_q[0].wdata);
      end
      n_checks++;
      if (alu_trace(W_val, W_pc, W_wdata) !== exp_trace) begin
        n_fail++;
        $display("FAIL bp_trace got \"%s\" required \"%s\"", alu_trace(W_val, W_pc, W_wdata), exp_trace);
      end
      @(posedge clk); #1;
    end
    W_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    a = exp_q.pop_front();
    if (D_rdy !== 1'b1 || W_val !== 1'b1 || W_pc !== a.pc || W_wdata !== a.wdata) begin
      n_fail++;
      $display("FAIL bp_release got D_rdy=%0b val=%0b pc=%h wdata=%h required D_rdy=1 val=1 pc=%h wdata=%h",
               D_rdy, W_val, W_pc, W_wdata, a.pc, a.wdata);
    end
    @(posedge clk); #1; D_val = 1'b0;
    @(negedge clk);
    n_checks++;
    b = exp_q.pop_front();
    if (W_val !== 1'b1 || W_pc !== b.pc || W_seq_num !== b.seq || W_waddr !== b.waddr || W_wdata !== b.wdata) begin
      n_fail++;
      $display("FAIL bp_second got val=%0b pc=%h seq=%0d waddr=%0d wdata=%h required val=1 pc=%h seq=%0d waddr=%0d wdata=%h",
               W_val, W_pc, W_seq_num, W_waddr, W_wdata, b.pc, b.seq, b.waddr, b.wdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (W_val !== 1'b0 || alu_trace(W_val, W_pc, W_wdata) !== blank_trace) begin
      n_fail++;
      $display("FAIL bp_idle got val=%0b trace=\"%s\" required val=0 and blank trace", W_val, alu_trace(W_val, W_pc, W_wdata));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      op_t o;
      o.pc    = 32'h4000 + 32'(4*i);
      o.seq   = SEQ_BITS'(i);
      o.waddr = 5'($urandom_range(0, 31));
      o.uop   = ($urandom_range(0, 11) == 11) ? rv_uop'(4'd14) : rv_uop'(4'($urandom_range(0, 10)));
      o.op1   = $urandom;
      o.op2   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      stim_q.push_back(with_model(o));
    end
    run_stream(3, 3, "random");
  endtask

  task automatic test_reset_mid();
    op_t o;
    W_rdy = 1'b0;
    drive_op(mk(32'h500, 6, 5'd9, UOP_ADD, 32'd1, 32'd1, 32'd2, 1'b1));
    @(posedge clk); #1; D_val = 1'b0;
    @(negedge clk);
    n_checks++;
    if (W_val !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pending got W_val=%0b required 1", W_val);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (W_val !== 1'b0 || W_wdata !== 32'd0 || W_wen !== 1'b0 || D_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_clear got val=%0b wdata=%h wen=%0b D_rdy=%0b required val=0 wdata=0 wen=0 D_rdy=1",
               W_val, W_wdata, W_wen, D_rdy);
    end
    @(posedge clk); #1; rst = 1'b1; W_rdy = 1'b1;
    o = mk(32'h600, 0, 5'd1, UOP_ADD, 32'd5, 32'd7, 32'd12, 1'b1);
    stim_q.push_back(o);
    run_stream(0, 0, "post_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Single-cycle integer ALU execute unit in the execute stage.
- Accepts decoded micro-ops from decode (D) over a val/rdy D__X channel.
- Computes a 32-bit result and returns it to writeback (W) over a val/rdy X__W channel.
- Pipelined one-entry output register, so it sustains one op per cycle when W is ready.

Parameters:
- p_seq_num_bits, 5, width of the instruction sequence number carried through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- D_val  in  1  D__X request valid.
- D_rdy  out  1  D__X request ready.
- D_pc  in  32  instruction PC.
- D_seq_num  in  p_seq_num_bits  sequence number.
- D_op1  in  32  operand 1 (rs1 value).
- D_op2  in  32  operand 2 (rs2 or immediate).
- D_waddr  in  5  destination register.
- D_uop  in  rv_uop  micro-op selector.
- W_val  out  1  X__W response valid.
- W_rdy  in  1  X__W response ready.
- W_pc  out  32  PC of the completed op.
- W_seq_num  out  p_seq_num_bits  sequence number of the completed op.
- W_waddr  out  5  destination register.
- W_wdata  out  32  result.
- W_wen  out  1  register write enable.

Behaviour:
- Reset (rst low, asynchronous): W_val=0; W_pc, W_seq_num, W_waddr, W_wdata, W_wen all cleared to 0. D_rdy=1 once out of reset.
- D_rdy = !W_val || W_rdy (combinational).
  - Output register empty, or draining this cycle, means a new op can be accepted.
- On posedge with D_val && D_rdy, load the output register:
  - pc, seq_num and waddr copied unchanged.
  - wdata = f(uop, op1, op2).
  - wen = 1 for every supported uop.
  - W_val = 1 the next cycle.
  - Latency is exactly 1 cycle from D handshake to W_val.
- On posedge with W_val && W_rdy and no new accept: W_val=0.
- Simultaneous drain and accept: register takes the new op and W_val stays 1, giving full throughput.
- W_val && !W_rdy: all W outputs hold stable and D_rdy=0; no op is dropped or duplicated.
- Operations (32-bit, results wrap modulo 2^32, no overflow flags):
  - ADD: op1+op2.
  - SUB: op1-op2.
  - AND, OR, XOR: bitwise.
  - SLL: op1 << op2[4:0].
  - SRL: logical right shift by op2[4:0].
  - SRA: arithmetic right shift by op2[4:0].
  - SLT: signed compare, result 1/0.
  - SLTU: unsigned compare, result 1/0.
  - LUI: wdata = op2 (immediate pre-shifted by decode).
- Unsupported uop: wdata=0, wen=0; the op still completes with normal handshake.
- waddr=0 still reports wen=1; writeback discards writes to x0.
- seq_num is opaque; wrap-around needs no special handling.
- Reset mid-operation: any pending output is discarded and W_val drops immediately.
- Provides a trace() function returning a fixed-width string:
  - pc and result when W_val is asserted.
  - blanks of the same width otherwise.

Decomposition:
- rv_uop enum and ISA-wide constants live in the shared UArch package.
- D__XIntf and X__WIntf interface definitions are shared in the codebase.
- Combinational datapath as a sub-module alu_datapath: (uop, op1, op2) -> (wdata, wen).
- Top level holds the val/rdy output register.

Test Plan:
- ADD, W_rdy tied 1: pc=0x200, seq=1, op1=1, op2=2, waddr=5 -> next cycle W: pc=0x200, seq=1, waddr=5, wdata=3, wen=1.
- Overflow and signedness:
  - ADD 0xFFFFFFFF+1 -> 0.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU same operands -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
- Back-to-back: 8 ADDs on consecutive cycles, seq 0..7 (wrap at 2^3 with p_seq_num_bits=3) -> 8 results in order, one per cycle.
- Back-pressure: W_rdy low 3 cycles with one result pending -> W outputs stable, D_rdy=0; after release, next op accepted in the same cycle as the drain.
- Random D send delays and W receive delays (0–3 cycles) over 20 ops -> all results in order, none lost or duplicated.
- Assert rst low while W_val=1 -> W_val=0 immediately; after release, first op 5+7 -> wdata=12.
